// File: rtl/select_share_arbiter.sv
// Round-robin arbiter that lends one elastic selector (condition/true/false -> result)
// to NUM_REQ requesters, holding the grant while a result or an antitoken is outstanding.
module select_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_TYPE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             ins_condition,
  input  logic [NUM_REQ-1:0]             ins_condition_valid,
  output logic [NUM_REQ-1:0]             ins_condition_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_true,
  input  logic [NUM_REQ-1:0]             ins_true_valid,
  output logic [NUM_REQ-1:0]             ins_true_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_false,
  input  logic [NUM_REQ-1:0]             ins_false_valid,
  output logic [NUM_REQ-1:0]             ins_false_ready,
  output logic [NUM_REQ*DATA_TYPE-1:0]   outs_result,
  output logic [NUM_REQ-1:0]             outs_result_valid,
  input  logic [NUM_REQ-1:0]             outs_result_ready,
  output logic                           sel_condition,
  output logic                           sel_condition_valid,
  input  logic                           sel_condition_ready,
  output logic [DATA_TYPE-1:0]           sel_true,
  output logic                           sel_true_valid,
  input  logic                           sel_true_ready,
  output logic [DATA_TYPE-1:0]           sel_false,
  output logic                           sel_false_valid,
  input  logic                           sel_false_ready,
  input  logic [DATA_TYPE-1:0]           sel_result,
  input  logic                           sel_result_valid,
  output logic                           sel_result_ready
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOCKED, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr, rr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic            drain_false_q, drain_false_d;

  logic [PW-1:0]   pick_idx, g;
  logic            pick_found, granted;
  int              off, best_off;

  logic                 g_cond, g_cv, g_tv, g_fv, g_rr;
  logic [DATA_TYPE-1:0] g_true, g_false;
  logic                 fwd_cond, fwd_true, fwd_false, fwd_res;
  logic                 transfer, unchosen_valid, drain_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr        <= '0;
      grant_q       <= '0;
      drain_false_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr        <= rr_d;
      grant_q       <= grant_d;
      drain_false_q <= drain_false_d;
    end
  end

  // Smallest rotational distance from rr_ptr wins among requesting channels.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    best_off   = NUM_REQ;
    off        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ins_condition_valid[i]) begin
        off = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
        if (off < best_off) begin
          best_off   = off;
          pick_idx   = PW'(i);
          pick_found = 1'b1;
        end
      end
    end
  end

  assign g       = (state_q == IDLE) ? pick_idx : grant_q;
  assign granted = (state_q != IDLE) || pick_found;

  always_comb begin
    g_cond  = 1'b0;
    g_cv    = 1'b0;
    g_tv    = 1'b0;
    g_fv    = 1'b0;
    g_rr    = 1'b0;
    g_true  = '0;
    g_false = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == g) begin
        g_cond  = ins_condition[i];
        g_cv    = ins_condition_valid[i];
        g_tv    = ins_true_valid[i];
        g_fv    = ins_false_valid[i];
        g_rr    = outs_result_ready[i];
        g_true  = ins_true[i*DATA_TYPE +: DATA_TYPE];
        g_false = ins_false[i*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  // While draining, only the side owed to the antitoken talks to the selector.
  assign fwd_cond  = granted && (state_q != DRAIN);
  assign fwd_res   = fwd_cond;
  assign fwd_true  = granted && ((state_q != DRAIN) || !drain_false_q);
  assign fwd_false = granted && ((state_q != DRAIN) || drain_false_q);

  always_comb begin
    sel_condition       = g_cond;
    sel_condition_valid = fwd_cond && g_cv;
    sel_true            = g_true;
    sel_true_valid      = fwd_true && g_tv;
    sel_false           = g_false;
    sel_false_valid     = fwd_false && g_fv;
    sel_result_ready    = fwd_res && g_rr;
    ins_condition_ready = '0;
    ins_true_ready      = '0;
    ins_false_ready     = '0;
    outs_result_valid   = '0;
    outs_result         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (granted && (PW'(i) == g)) begin
        ins_condition_ready[i]               = fwd_cond && sel_condition_ready;
        ins_true_ready[i]                    = fwd_true && sel_true_ready;
        ins_false_ready[i]                   = fwd_false && sel_false_ready;
        outs_result_valid[i]                 = fwd_res && sel_result_valid;
        outs_result[i*DATA_TYPE +: DATA_TYPE] = sel_result;
      end
    end
  end

  assign transfer       = fwd_res && sel_result_valid && g_rr;
  assign unchosen_valid = g_cond ? g_fv : g_tv;
  assign drain_done     = drain_false_q ? (g_fv && sel_false_ready) : (g_tv && sel_true_ready);

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_ptr;
    grant_d       = grant_q;
    drain_false_d = drain_false_q;
    case (state_q)
      IDLE, LOCKED: begin
        if (transfer) begin
          grant_d = g;
          rr_d    = (g == PW'(NUM_REQ - 1)) ? '0 : g + PW'(1);
          if (!unchosen_valid) begin
            state_d       = DRAIN;
            drain_false_d = g_cond;
          end else begin
            state_d = IDLE;
          end
        end else if (granted && sel_result_valid) begin
          state_d = LOCKED;
          grant_d = g;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
